// File: rtl/lane_surfer_pkg.sv
// Shared constants and types for the lane-surfer game datapath.
// Geometry is in pixels; rows grow downward from 0 at the top of the screen.
package lane_surfer_pkg;

    localparam int unsigned N_OBST        = 4;
    localparam int unsigned N_LANES       = 3;
    localparam logic [6:0]  PLAYER_Y      = 7'd100;
    localparam int unsigned PLAYER_H      = 8;
    localparam int unsigned OBST_H        = 8;
    localparam int unsigned INVULN_FRAMES = 60;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REPORT
    } state_t;

    function automatic logic lane_valid(input logic [1:0] lane);
        return 32'(lane) < N_LANES;
    endfunction

endpackage

// File: rtl/obstacle_overlap.sv
// Combinational hit test for one obstacle slot against the player box.
// Sums are widened to 8 bits so an obstacle near row 127 cannot wrap into the player.
module obstacle_overlap #(
    parameter logic [6:0]  PLAYER_Y = lane_surfer_pkg::PLAYER_Y,
    parameter int unsigned PLAYER_H = lane_surfer_pkg::PLAYER_H,
    parameter int unsigned OBST_H   = lane_surfer_pkg::OBST_H
) (
    input  logic       i_active,
    input  logic [1:0] i_obst_lane,
    input  logic [6:0] i_obst_y,
    input  logic [1:0] i_player_lane,
    output logic       o_hit
);
    import lane_surfer_pkg::*;

    logic [7:0] w_obst_top;
    logic [7:0] w_obst_bot;
    logic [7:0] w_player_top;
    logic [7:0] w_player_bot;
    logic       w_same_lane;
    logic       w_vert_overlap;

    assign w_obst_top   = {1'b0, i_obst_y};
    assign w_obst_bot   = w_obst_top + 8'(OBST_H);
    assign w_player_top = {1'b0, PLAYER_Y};
    assign w_player_bot = w_player_top + 8'(PLAYER_H);

    assign w_same_lane    = lane_valid(i_player_lane) && (i_obst_lane == i_player_lane);
    assign w_vert_overlap = (w_obst_bot > w_player_top) && (w_obst_top < w_player_bot);

    assign o_hit = i_active && w_same_lane && w_vert_overlap;

endmodule

// File: rtl/collision_detector.sv
// Per-frame obstacle scanner: walks one slot per cycle, reports the first hit
// as a one-cycle pulse and holds off further hits for a number of frames.
module collision_detector #(
    parameter int unsigned N_OBST        = lane_surfer_pkg::N_OBST,
    parameter logic [6:0]  PLAYER_Y      = lane_surfer_pkg::PLAYER_Y,
    parameter int unsigned PLAYER_H      = lane_surfer_pkg::PLAYER_H,
    parameter int unsigned OBST_H        = lane_surfer_pkg::OBST_H,
    parameter int unsigned INVULN_FRAMES = lane_surfer_pkg::INVULN_FRAMES,
    localparam int unsigned IDX_W        = (N_OBST > 1) ? $clog2(N_OBST) : 1
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  i_frame_tick,
    input  logic                  i_game_over,
    input  logic [1:0]            i_player_lane,
    input  logic [N_OBST-1:0]     i_obst_active,
    input  logic [2*N_OBST-1:0]   i_obst_lane,
    input  logic [7*N_OBST-1:0]   i_obst_y,
    output logic                  o_collision,
    output logic [IDX_W-1:0]      o_hit_index,
    output logic                  o_invuln
);
    import lane_surfer_pkg::*;

    localparam int unsigned CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_slot;
    logic [IDX_W-1:0] r_cand_idx;
    logic             r_cand_valid;
    logic [IDX_W-1:0] r_hit_index;
    logic [1:0]       r_lane;
    logic             r_go_seen;
    logic [CNT_W-1:0] r_invuln_cnt;

    logic             w_slot_active;
    logic [1:0]       w_slot_lane;
    logic [6:0]       w_slot_y;
    logic             w_slot_hit;
    logic             w_idle_tick;
    logic             w_start;
    logic             w_last_slot;
    logic             w_fire;

    always_comb begin
        w_slot_active = 1'b0;
        w_slot_lane   = '0;
        w_slot_y      = '0;
        for (int unsigned i = 0; i < N_OBST; i++) begin
            if (r_slot == IDX_W'(i)) begin
                w_slot_active = i_obst_active[i];
                w_slot_lane   = i_obst_lane[2*i +: 2];
                w_slot_y      = i_obst_y[7*i +: 7];
            end
        end
    end

    obstacle_overlap #(
        .PLAYER_Y (PLAYER_Y),
        .PLAYER_H (PLAYER_H),
        .OBST_H   (OBST_H)
    ) u_overlap (
        .i_active      (w_slot_active),
        .i_obst_lane   (w_slot_lane),
        .i_obst_y      (w_slot_y),
        .i_player_lane (r_lane),
        .o_hit         (w_slot_hit)
    );

    assign w_idle_tick = (r_state == S_IDLE) && i_frame_tick;
    assign w_start     = w_idle_tick && !i_game_over;
    assign w_last_slot = (r_slot == IDX_W'(N_OBST - 1));

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_start)     w_next_state = S_SCAN;
            S_SCAN:   if (w_last_slot) w_next_state = S_REPORT;
            S_REPORT:                  w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    // A game_over seen at any point during the scan suppresses this frame's report.
    always_comb begin
        w_fire = 1'b0;
        if (r_state == S_REPORT && r_cand_valid && r_invuln_cnt == '0
            && !i_game_over && !r_go_seen) begin
            w_fire = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_slot       <= '0;
            r_cand_idx   <= '0;
            r_cand_valid <= 1'b0;
            r_hit_index  <= '0;
            r_lane       <= '0;
            r_go_seen    <= 1'b0;
            r_invuln_cnt <= '0;
        end else begin
            if (w_start) begin
                r_lane       <= i_player_lane;
                r_cand_valid <= 1'b0;
                r_cand_idx   <= '0;
                r_slot       <= '0;
                r_go_seen    <= 1'b0;
            end
            if (w_idle_tick && r_invuln_cnt != '0) begin
                r_invuln_cnt <= r_invuln_cnt - 1'b1;
            end
            if (r_state == S_SCAN) begin
                r_slot <= r_slot + 1'b1;
                if (w_slot_hit && !r_cand_valid) begin
                    r_cand_valid <= 1'b1;
                    r_cand_idx   <= r_slot;
                end
                if (i_game_over) begin
                    r_go_seen <= 1'b1;
                end
            end
            if (w_fire) begin
                r_hit_index  <= r_cand_idx;
                r_invuln_cnt <= CNT_W'(INVULN_FRAMES);
            end
        end
    end

    assign o_collision = w_fire;
    assign o_hit_index = w_fire ? r_cand_idx : r_hit_index;
    assign o_invuln    = (r_invuln_cnt != '0);

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed scenarios plus randomized frames
// scored against a frame-level behavioural model.
module tb_collision_detector;

    localparam int NO  = 4;
    localparam int PY  = 100;
    localparam int PH  = 8;
    localparam int OH  = 8;
    localparam int INV = 60;
    localparam int IW  = 2;

    logic            Clock = 1'b0;
    logic            Resetn;
    logic            frame_tick;
    logic            game_over;
    logic [1:0]      player_lane;
    logic [NO-1:0]   obst_active;
    logic [2*NO-1:0] obst_lane;
    logic [7*NO-1:0] obst_y;
    logic            collision;
    logic [IW-1:0]   hit_index;
    logic            invuln;

    int checks   = 0;
    int failures = 0;
    int m_cnt    = 0;
    int m_hidx   = 0;

    always #5 Clock = ~Clock;

    collision_detector dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .i_frame_tick  (frame_tick),
        .i_game_over   (game_over),
        .i_player_lane (player_lane),
        .i_obst_active (obst_active),
        .i_obst_lane   (obst_lane),
        .i_obst_y      (obst_y),
        .o_collision   (collision),
        .o_hit_index   (hit_index),
        .o_invuln      (invuln)
    );

    // Lowest slot whose box overlaps the player's box in the player's lane.
    function automatic int first_hit(input logic [NO-1:0] act, input logic [2*NO-1:0] ln,
                                     input logic [7*NO-1:0] ys, input logic [1:0] pl);
        if (pl == 2'd3) return -1;
        for (int i = 0; i < NO; i++) begin
            int y;
            y = int'(ys[7*i +: 7]);
            if (act[i] && ln[2*i +: 2] == pl && y + OH > PY && y < PY + PH) return i;
        end
        return -1;
    endfunction

    task automatic model_frame(input int hit, output bit fire, output bit inv_early,
                               output bit inv_late);
        if (m_cnt > 0) m_cnt--;
        inv_early = (m_cnt != 0);
        fire = (hit >= 0) && (m_cnt == 0);
        if (fire) begin
            m_cnt  = INV;
            m_hidx = hit;
        end
        inv_late = (m_cnt != 0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        m_cnt = 0; m_hidx = 0;
    endtask

    task automatic set_obst(input logic [NO-1:0] act, input logic [2*NO-1:0] ln,
                            input logic [7*NO-1:0] ys, input logic [1:0] pl);
        obst_active = act; obst_lane = ln; obst_y = ys; player_lane = pl;
    endtask

    // Issues one frame_tick at a negedge and observes the following N_OBST+2 cycles.
    task automatic drive_frame(output int npulse, output int pcycle, output logic [IW-1:0] hidx,
                               output logic inv_early, output logic inv_late);
        frame_tick = 1'b1;
        npulse = 0; pcycle = -1; inv_early = 1'b0;
        for (int c = 1; c <= NO + 1; c++) begin
            @(negedge Clock);
            frame_tick = 1'b0;
            if (c == 1) inv_early = invuln;
            if (collision) begin
                npulse++;
                if (pcycle < 0) pcycle = c;
            end
        end
        @(negedge Clock);
        if (collision) npulse++;
        inv_late = invuln;
        hidx     = hit_index;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (collision !== 1'b0) begin failures++; $display("FAIL reset_collision: got %b expected 0", collision); end
        checks++; if (hit_index !== '0) begin failures++; $display("FAIL reset_hit_index: got %0d expected 0", hit_index); end
        checks++; if (invuln !== 1'b0) begin failures++; $display("FAIL reset_invuln: got %b expected 0", invuln); end
    endtask

    task automatic test_basic();
        int np, pc; logic [IW-1:0] hi; logic ie, il; bit f, e_ie, e_il;
        do_reset();
        set_obst(4'b0100, 8'b00_01_00_00, {7'd0, 7'd96, 7'd0, 7'd0}, 2'd1);
        drive_frame(np, pc, hi, ie, il);
        model_frame(2, f, e_ie, e_il);
        checks++; if (np !== 1) begin failures++; $display("FAIL basic_pulses: got %0d expected 1", np); end
        checks++; if (pc !== NO + 1) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", pc, NO + 1); end
        checks++; if (hi !== 2'd2) begin failures++; $display("FAIL basic_hit_index: got %0d expected 2", hi); end
        checks++; if (il !== 1'b1) begin failures++; $display("FAIL basic_invuln: got %b expected 1", il); end
    endtask

    // Continues from test_basic: the same overlap for 60 more frames.
    task automatic test_invuln_window();
        int np, pc, total; logic [IW-1:0] hi; logic ie, il; bit f, e_ie, e_il;
        total = 0;
        for (int fr = 2; fr <= 61; fr++) begin
            drive_frame(np, pc, hi, ie, il);
            model_frame(2, f, e_ie, e_il);
            total += np;
            checks++; if (np !== int'(f)) begin failures++; $display("FAIL window_pulse frame %0d: got %0d expected %0d", fr, np, f); end
            checks++; if (ie !== e_ie) begin failures++; $display("FAIL window_invuln_early frame %0d: got %b expected %b", fr, ie, e_ie); end
            checks++; if (il !== e_il) begin failures++; $display("FAIL window_invuln_late frame %0d: got %b expected %b", fr, il, e_il); end
            if (fr == 61) begin
                checks++; if (ie !== 1'b0) begin failures++; $display("FAIL window_invuln_fall: got %b expected 0", ie); end
                checks++; if (np !== 1 || pc !== NO + 1) begin failures++; $display("FAIL window_frame61: got pulses=%0d cycle=%0d expected 1 at %0d", np, pc, NO + 1); end
            end
        end
        checks++; if (total !== 1) begin failures++; $display("FAIL window_total: got %0d expected 1", total); end
    endtask

    task automatic test_priority();
        int np, pc; logic [IW-1:0] hi; logic ie, il;
        do_reset();
        set_obst(4'b1010, 8'b10_00_10_00, {7'd95, 7'd0, 7'd100, 7'd0}, 2'd2);
        drive_frame(np, pc, hi, ie, il);
        checks++; if (np !== 1) begin failures++; $display("FAIL priority_pulses: got %0d expected 1", np); end
        checks++; if (hi !== 2'd1) begin failures++; $display("FAIL priority_hit_index: got %0d expected 1", hi); end
    endtask

    task automatic test_boundary();
        int ys [6] = '{92, 93, 107, 108, 127, 0};
        int ex [6] = '{0, 1, 1, 0, 0, 0};
        int np, pc; logic [IW-1:0] hi; logic ie, il;
        for (int k = 0; k < 6; k++) begin
            do_reset();
            set_obst(4'b0001, 8'b00_00_00_00, {21'd0, 7'(ys[k])}, 2'd0);
            drive_frame(np, pc, hi, ie, il);
            checks++; if (np !== ex[k]) begin failures++; $display("FAIL boundary_y%0d: got %0d pulses expected %0d", ys[k], np, ex[k]); end
        end
        do_reset();
        set_obst(4'b0001, 8'b00_00_00_11, {21'd0, 7'd100}, 2'd3);
        drive_frame(np, pc, hi, ie, il);
        checks++; if (np !== 0) begin failures++; $display("FAIL boundary_lane3: got %0d pulses expected 0", np); end
    endtask

    task automatic test_game_over();
        int np, pc; logic [IW-1:0] hi; logic ie, il;
        do_reset();
        set_obst(4'b0001, 8'b00_00_00_01, {21'd0, 7'd100}, 2'd1);
        game_over = 1'b1;
        drive_frame(np, pc, hi, ie, il);
        game_over = 1'b0;
        checks++; if (np !== 0) begin failures++; $display("FAIL gameover_held: got %0d pulses expected 0", np); end
        checks++; if (il !== 1'b0) begin failures++; $display("FAIL gameover_invuln: got %b expected 0", il); end
        // game_over blips mid-scan while a second tick lands in the scan
        np = 0;
        frame_tick = 1'b1;
        for (int c = 1; c <= 2 * NO + 4; c++) begin
            @(negedge Clock);
            frame_tick = (c == 2);
            game_over  = (c == 2);
            if (collision) np++;
        end
        checks++; if (np !== 0) begin failures++; $display("FAIL gameover_midscan: got %0d pulses expected 0", np); end
        checks++; if (invuln !== 1'b0) begin failures++; $display("FAIL gameover_midscan_invuln: got %b expected 0", invuln); end
    endtask

    task automatic test_back_to_back();
        int np, pc;
        do_reset();
        set_obst(4'b0001, 8'b00_00_00_00, {21'd0, 7'd97}, 2'd0);
        np = 0; pc = -1;
        frame_tick = 1'b1;
        for (int c = 1; c <= 2 * NO + 4; c++) begin
            @(negedge Clock);
            frame_tick = (c == 2);
            if (collision) begin np++; if (pc < 0) pc = c; end
        end
        checks++; if (np !== 1) begin failures++; $display("FAIL ignored_tick_pulses: got %0d expected 1", np); end
        checks++; if (pc !== NO + 1) begin failures++; $display("FAIL ignored_tick_latency: got %0d expected %0d", pc, NO + 1); end
    endtask

    task automatic test_reset_mid_scan();
        int np, pc; logic [IW-1:0] hi; logic ie, il;
        do_reset();
        set_obst(4'b1000, 8'b11_00_00_00, {7'd100, 21'd0}, 2'd3);
        player_lane = 2'd2;
        obst_lane   = 8'b10_00_00_00;
        np = 0;
        frame_tick = 1'b1;
        for (int c = 1; c <= NO + 3; c++) begin
            @(negedge Clock);
            frame_tick = 1'b0;
            Resetn = !(c == 3);
            if (collision) np++;
        end
        m_cnt = 0; m_hidx = 0;
        checks++; if (np !== 0) begin failures++; $display("FAIL rstscan_pulses: got %0d expected 0", np); end
        checks++; if (invuln !== 1'b0) begin failures++; $display("FAIL rstscan_invuln: got %b expected 0", invuln); end
        checks++; if (hit_index !== '0) begin failures++; $display("FAIL rstscan_hit_index: got %0d expected 0", hit_index); end
        drive_frame(np, pc, hi, ie, il);
        checks++; if (np !== 1 || pc !== NO + 1) begin failures++; $display("FAIL rstscan_next_frame: got pulses=%0d cycle=%0d expected 1 at %0d", np, pc, NO + 1); end
        checks++; if (hi !== 2'd3) begin failures++; $display("FAIL rstscan_next_index: got %0d expected 3", hi); end
    endtask

    task automatic test_random();
        int np, pc, h; logic [IW-1:0] hi; logic ie, il; bit f, e_ie, e_il;
        logic [NO-1:0] act; logic [2*NO-1:0] ln; logic [7*NO-1:0] ys; logic [1:0] pl;
        do_reset();
        for (int fr = 0; fr < 300; fr++) begin
            if ($urandom_range(0, 24) == 0) do_reset();
            act = NO'($urandom);
            for (int i = 0; i < NO; i++) begin
                ln[2*i +: 2] = 2'($urandom_range(0, 3));
                ys[7*i +: 7] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                           : 7'($urandom_range(88, 127));
            end
            pl = 2'($urandom_range(0, 3));
            set_obst(act, ln, ys, pl);
            drive_frame(np, pc, hi, ie, il);
            h = first_hit(act, ln, ys, pl);
            model_frame(h, f, e_ie, e_il);
            checks++; if (np !== int'(f)) begin failures++; $display("FAIL rand_pulse frame %0d: got %0d expected %0d", fr, np, f); end
            if (f) begin
                checks++; if (pc !== NO + 1) begin failures++; $display("FAIL rand_latency frame %0d: got %0d expected %0d", fr, pc, NO + 1); end
            end
            checks++; if (int'(hi) !== m_hidx) begin failures++; $display("FAIL rand_hit_index frame %0d: got %0d expected %0d", fr, hi, m_hidx); end
            checks++; if (ie !== e_ie) begin failures++; $display("FAIL rand_invuln_early frame %0d: got %b expected %b", fr, ie, e_ie); end
            checks++; if (il !== e_il) begin failures++; $display("FAIL rand_invuln_late frame %0d: got %b expected %b", fr, il, e_il); end
        end
    endtask

    initial begin
        Resetn = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
        player_lane = '0; obst_active = '0; obst_lane = '0; obst_y = '0;
        test_reset();
        test_basic();
        test_invuln_window();
        test_priority();
        test_boundary();
        test_game_over();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter N_OBST, default 4, number of obstacle slots scanned per frame.
REQ-002 SHALL have parameters PLAYER_Y (7'd100), PLAYER_H (8), OBST_H (8), giving player top row and player/obstacle heights in pixels.
REQ-003 SHALL have parameter INVULN_FRAMES, default 60, giving post-hit immunity length in frames.
REQ-004 Clock  input  1  system clock; all state on rising edge.
REQ-005 Resetn  input  1  synchronous, active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse that starts one collision scan.
REQ-007 game_over  input  1  high freezes detection.
REQ-008 player_lane  input  2  current player lane, 0-2; 3 is invalid.
REQ-009 obst_active  input  N_OBST  per-slot valid bit.
REQ-010 obst_lane  input  2*N_OBST  packed lanes; slot i at bits [2i+1:2i].
REQ-011 obst_y  input  7*N_OBST  packed top rows; slot i at bits [7i+6:7i].
REQ-012 collision  output  1  one-cycle hit pulse to the lives/game-over stage.
REQ-013 hit_index  output  clog2(N_OBST)  slot of the last reported hit.
REQ-014 invuln  output  1  high while immunity is active; used for player blink.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN and REPORT.
REQ-016 In IDLE, frame_tick=1 with game_over=0 SHALL snapshot player_lane, clear the per-frame hit flag, set slot counter to 0 and enter SCAN.
REQ-017 SCAN SHALL examine one slot per cycle, slots 0 to N_OBST-1, then enter REPORT; the scan lasts exactly N_OBST cycles.
REQ-018 Slot i SHALL hit only if all hold: active, obst_lane equals the snapshot lane, obst_y+OBST_H > PLAYER_Y, and obst_y < PLAYER_Y+PLAYER_H.
REQ-019 Geometry sums SHALL be computed 8 bits wide, so no wrap-around occurs at obst_y=127.
REQ-020 A snapshot lane of 3 SHALL produce no hits.
REQ-021 The first (lowest-index) hitting slot SHALL be latched as the candidate; later hits in the same frame SHALL be ignored.
REQ-022 REPORT SHALL last one cycle and return to IDLE.
REQ-023 In REPORT, if a candidate exists, invuln counter = 0 and game_over = 0, the block SHALL pulse collision for exactly that cycle, update hit_index and load the counter with INVULN_FRAMES.
REQ-024 collision SHALL go high N_OBST+1 cycles after the cycle in which frame_tick is sampled, and at most once per frame.
REQ-025 A frame_tick that arrives while the FSM is in SCAN or REPORT SHALL be ignored.
REQ-026 The invuln counter SHALL decrement by 1 on each frame_tick sampled in IDLE while nonzero, and SHALL saturate at 0.
REQ-027 invuln SHALL equal (counter != 0).
REQ-028 If game_over is high in any cycle, the block SHALL force collision to 0; if game_over rises mid-scan, the scan SHALL complete without a pulse.
REQ-029 Obstacle inputs SHALL be sampled in the cycle of their scan slot; the producer holds them stable for N_OBST+1 cycles after frame_tick.

Reset
REQ-030 On Resetn=0, the FSM SHALL enter IDLE, collision=0, hit_index=0, invuln counter=0 (so invuln=0), and all candidate/snapshot state SHALL clear.
REQ-031 Reset during SCAN or REPORT SHALL abort the scan with no collision pulse on the following cycle.

Structure
REQ-032 The shared package lane_surfer_pkg SHALL hold N_OBST, lane-count and geometry constants (PLAYER_Y, PLAYER_H, OBST_H), INVULN_FRAMES and the FSM state typedef.
REQ-033 The per-slot lane and vertical test SHALL be a combinational sub-module named obstacle_overlap; the FSM, counters and registers remain in collision_detector.

Verification
REQ-034 Lane 1, slot 2 active at lane 1, y=96, frame_tick -> collision=1 exactly 5 cycles later, hit_index=2, invuln=1.
REQ-035 Same overlap held for 61 consecutive frames -> pulses on frame 1 and frame 61 only; invuln falls after the 60th subsequent tick.
REQ-036 Slots 1 and 3 both overlap -> a single pulse with hit_index=1.
REQ-037 Boundary values: obst_y=92 (92+8=100, not greater than 100) -> no hit; obst_y=93 -> hit; obst_y=108 -> no hit; obst_y=127 -> no hit, no wrap.
REQ-038 game_over=1 with overlap present, and a second frame_tick 2 cycles into a scan -> no pulse for either, and the second tick is ignored.
REQ-039 Resetn=0 asserted mid-scan with a pending hit -> collision stays 0, invuln=0, next frame behaves as after power-up.
